uart_tx_framer: RTL and testbench



---
 rtl/uart_tx_framer.sv | 151 +++++++++++++++
 tb/tb_uart_tx_framer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// UART transmitter: start, DATA_WIDTH data bits LSB-first, optional parity, stop; each bit held Prescale cycles.
// Define UART_TX_TWO_STOP_EN to send two stop bits per frame.
module uart_tx_framer #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      Busy
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [PRESCALE_WIDTH-1:0] CNT_ONE = PRESCALE_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
  logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      par_en_q, par_en_d;
  logic                      par_typ_q, par_typ_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      bit_end;
`ifdef UART_TX_TWO_STOP_EN
  logic                      stop2_q, stop2_d;
`endif

  assign bit_end = (cnt_q == pre_q);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pre_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q   <= stop2_d;
`endif
    end
  end

  // Next-state logic also computes the next TX_OUT/Busy so both leave the block registered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pre_d     = pre_q;
    idx_d     = idx_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
`ifdef UART_TX_TWO_STOP_EN
    stop2_d   = stop2_q;
`endif
    if (state_q == IDLE) begin
      if (Data_Valid) begin
        state_d   = START;
        data_d    = P_DATA;
        par_en_d  = PAR_EN;
        par_typ_d = PAR_TYP;
        pre_d     = (Prescale == '0) ? CNT_ONE : Prescale;
        cnt_d     = CNT_ONE;
        idx_d     = '0;
        tx_d      = 1'b0;
        busy_d    = 1'b1;
      end
    end else if (!bit_end) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = CNT_ONE;
      case (state_q)
        START: begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = data_q[0];
        end
        DATA: begin
          if (idx_q == LAST_IDX) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = (^data_q) ^ par_typ_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q + IDX_ONE;
            tx_d  = data_q[idx_d];
          end
        end
        PARITY: begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
        STOP: begin
`ifdef UART_TX_TWO_STOP_EN
          if (!stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            stop2_d = 1'b0;
            state_d = IDLE;
            busy_d  = 1'b0;
          end
`else
          state_d = IDLE;
          busy_d  = 1'b0;
`endif
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench for uart_tx_framer: per-cycle line scoreboard plus frame vector table.
module tb_uart_tx_framer;

`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [4:0] Prescale;
  logic       TX_OUT;
  logic       Busy;

  uart_tx_framer #(.DATA_WIDTH(8), .PRESCALE_WIDTH(5)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Prescale(Prescale),
    .TX_OUT(TX_OUT), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       tx;
    logic       busy;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic [4:0] pre;
    logic       exp_par;
    int         exp_busy;   // one-stop-bit Busy length
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;
  int   busy_seen = 0;
  int   cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One cycle: sample at the falling edge and compare against the scoreboard (idle when empty).
  task automatic tick();
    exp_t e;
    @(negedge CLK);
    cyc++;
    if (Busy === 1'b1) busy_seen++;
    if (sb.size() > 0) e = sb.pop_front();
    else begin
      e.tx = 1'b1;
      e.busy = 1'b0;
    end
    check("line", {30'd0, TX_OUT, Busy}, {30'd0, e.tx, e.busy});
  endtask

  task automatic push_bit(input logic b, input int p);
    exp_t e;
    e.tx = b;
    e.busy = 1'b1;
    repeat (p) sb.push_back(e);
  endtask

  task automatic push_frame(input logic [7:0] d, input logic pe, input logic pbit, input int p);
    push_bit(1'b0, p);
    for (int i = 0; i < 8; i++) push_bit(d[i], p);
    if (pe) push_bit(pbit, p);
    for (int s = 0; s < STOP_BITS; s++) push_bit(1'b1, p);
  endtask

  function automatic int eff_p(input logic [4:0] pre);
    return (pre == 5'd0) ? 1 : int'(pre);
  endfunction

  function automatic int frame_len(input logic pe);
    return 1 + 8 + (pe ? 1 : 0) + STOP_BITS;
  endfunction

  // Called right after a falling edge: request is accepted at the next rising edge.
  task automatic send_frame(input vec_t v, input string name);
    int p, start;
    p = eff_p(v.pre);
    P_DATA = v.data;
    PAR_EN = v.pe;
    PAR_TYP = v.pt;
    Prescale = v.pre;
    Data_Valid = 1'b1;
    push_frame(v.data, v.pe, v.exp_par, p);
    start = busy_seen;
    tick();
    Data_Valid = 1'b0;
    P_DATA = ~v.data;
    PAR_TYP = ~v.pt;
    Prescale = 5'd3;
    repeat (frame_len(v.pe) * p) tick();
    check(name, busy_seen - start, v.exp_busy + (STOP_BITS - 1) * p);
  endtask

  initial begin
    int p;
    vecs[0] = '{data: 8'hA5, pe: 1'b0, pt: 1'b0, pre: 5'd8,  exp_par: 1'b0, exp_busy: 80};
    vecs[1] = '{data: 8'hA5, pe: 1'b1, pt: 1'b0, pre: 5'd4,  exp_par: 1'b0, exp_busy: 44};
    vecs[2] = '{data: 8'hA5, pe: 1'b1, pt: 1'b1, pre: 5'd4,  exp_par: 1'b1, exp_busy: 44};
    vecs[3] = '{data: 8'h3C, pe: 1'b0, pt: 1'b0, pre: 5'd3,  exp_par: 1'b0, exp_busy: 30};
    vecs[4] = '{data: 8'h81, pe: 1'b1, pt: 1'b0, pre: 5'd1,  exp_par: 1'b0, exp_busy: 11};
    vecs[5] = '{data: 8'h01, pe: 1'b1, pt: 1'b1, pre: 5'd31, exp_par: 1'b0, exp_busy: 341};
    vecs[6] = '{data: 8'h00, pe: 1'b0, pt: 1'b0, pre: 5'd0,  exp_par: 1'b0, exp_busy: 10};
    vecs[7] = '{data: 8'hA5, pe: 1'b0, pt: 1'b0, pre: 5'd4,  exp_par: 1'b0, exp_busy: 40};

    RST = 1'b1;
    P_DATA = 8'h00;
    Data_Valid = 1'b0;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    Prescale = 5'd8;
    #1;
    check("reset_tx", {31'd0, TX_OUT}, 32'd1);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    Data_Valid = 1'b1;
    repeat (3) tick();
    Data_Valid = 1'b0;
    RST = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i], $sformatf("busy_len_v%0d", i));
      repeat (2) tick();
    end

    // Mid-frame request with new settings must be ignored entirely.
    P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 5'd16;
    Data_Valid = 1'b1;
    push_frame(8'h3C, 1'b0, 1'b0, 16);
    tick();
    Data_Valid = 1'b0;
    repeat (29) tick();
    P_DATA = 8'hFF; Prescale = 5'd2; PAR_EN = 1'b1; Data_Valid = 1'b1;
    repeat (10) tick();
    Data_Valid = 1'b0;
    repeat (frame_len(1'b0) * 16 - 40 + 20) tick();

    // Back-to-back with Data_Valid held: one idle-high cycle between frames.
    for (int g = 0; g < 2; g++) begin
      P_DATA = 8'h00; PAR_EN = 1'b0; Prescale = (g == 0) ? 5'd1 : 5'd0;
      Data_Valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
        push_frame(8'h00, 1'b0, 1'b0, 1);
        repeat (frame_len(1'b0)) tick();
        if (k < 2) tick();
      end
      Data_Valid = 1'b0;
      repeat (5) tick();
    end

    // Reset during DATA bit 3 aborts the frame at once.
    P_DATA = 8'hFF; PAR_EN = 1'b0; Prescale = 5'd8; Data_Valid = 1'b1;
    push_frame(8'hFF, 1'b0, 1'b0, 8);
    tick();
    Data_Valid = 1'b0;
    repeat (33) tick();
    check("pre_abort_busy", {31'd0, Busy}, 32'd1);
    RST = 1'b1;
    #1;
    check("abort_tx", {31'd0, TX_OUT}, 32'd1);
    check("abort_busy", {31'd0, Busy}, 32'd0);
    sb.delete();
    repeat (3) tick();
    RST = 1'b0;
    repeat (2) tick();
    p = 8;
    send_frame('{data: 8'h55, pe: 1'b0, pt: 1'b0, pre: 5'd8, exp_par: 1'b0, exp_busy: 80},
               "post_reset_busy");
    repeat (4) tick();
    check("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
